wb_stage_buf: RTL and testbench
===============================

// Module: wb_stage_buf
// PURPOSE
//  Parametrised writeback stage, successor to the single-cycle WB mux.
//  Accepts MEM/WB results over a valid/ready handshake and aligns and sign-extends
//  sub-word loads. Arbitrates the single register-file write port against a
//  long-latency unit (LLU) result channel; pipeline results queue in an in-order FIFO.
//  Sits between the MEM stage / LLU and the register-file write port.
// PARAMETERS
//  DATA_W      32  datapath and register width (multiple of 8, >=32)
//  ADDR_W      5   register address width
//  FIFO_DEPTH  4   pipeline-result queue depth (power of 2, >=2)
// PORTS
//  clk_i                    in   1        clock, rising edge
//  rst_i                    in   1        asynchronous reset, active-high
//  MEMWB_valid_i            in   1        MEM/WB result valid
//  MEMWB_ready_o            out  1        stage can accept a result
//  MEMWB_mem_i              in   DATA_W   raw memory read word
//  MEMWB_alu_i              in   DATA_W   ALU result
//  MEMWB_rd_i               in   ADDR_W   destination register
//  MEMWB_ctrl_reg_write_i   in   1        result writes the register file
//  MEMWB_ctrl_mem_to_reg_i  in   1        1 = load data, 0 = ALU data
//  MEMWB_ld_size_i          in   2        00 byte, 01 half, 10/11 word
//  MEMWB_ld_unsigned_i      in   1        1 = zero-extend, 0 = sign-extend
//  MEMWB_ld_offset_i        in   2        byte offset of the load address
//  LLU_valid_i              in   1        LLU result valid (no backpressure)
//  LLU_rd_i                 in   ADDR_W   LLU destination register
//  LLU_data_i               in   DATA_W   LLU result
//  WB_reg_write_address_o   out  ADDR_W   register-file write address (registered)
//  WB_reg_write_data_o      out  DATA_W   register-file write data (registered)
//  WB_ctrl_reg_write_o      out  1        register-file write enable (registered)
//  WB_fifo_count_o          out  $clog2(FIFO_DEPTH)+1  queued entries
// BEHAVIOUR
//  - Reset: all outputs 0 except MEMWB_ready_o=1; FIFO emptied; counters 0.
//    Reset mid-operation discards queued and in-flight results.
//  - MEMWB_ready_o = (count < FIFO_DEPTH). Depends only on registered state, never
//    on valid. accept = MEMWB_valid_i & MEMWB_ready_o.
//  - A result is writeable if ctrl_reg_write=1 and rd!=0. Accepted non-writeable
//    results are consumed and dropped.
//  - Load align: lane = offset (byte), {offset[1],0} (half); word ignores offset.
//    Extended to DATA_W by zero or sign per ld_unsigned. Misaligned half uses offset[1].
//  - Port grant each cycle, priority order:
//    1. LLU_valid_i with LLU_rd_i!=0.
//    2. FIFO head (pop).
//    3. Bypass: writeable accept while FIFO empty.
//    LLU with rd=0 is ignored and does not take the port.
//  - Granted result is registered into the WB_* outputs at the next edge, so
//    latency is 1 cycle. WB_ctrl_reg_write_o=0 on cycles with no grant; address
//    and data then hold their previous values.
//  - Push: a writeable accept enters the FIFO unless it wins bypass. Push and pop
//    may occur in the same cycle and count then stays unchanged. Ordering of
//    pipeline results is always preserved.
//  - Pointers wrap modulo FIFO_DEPTH. count never exceeds FIFO_DEPTH; push at full
//    cannot occur because ready=0.
//  - RAW ordering between LLU and pipeline results to the same rd is guaranteed
//    by the issue scoreboard, not by this block.
// CONFIGURATION
//  WB_STALL_CNT_EN defined: adds outputs WB_stall_cnt_o[31:0] and
//    WB_conflict_cnt_o[31:0].
//    stall_cnt increments on cycles with MEMWB_valid_i & ~MEMWB_ready_o.
//    conflict_cnt increments when an LLU grant forces a writeable accept into the FIFO.
//    Both saturate at 32'hFFFF_FFFF and reset to 0.
//  WB_STALL_CNT_EN undefined: no counters and no such ports. All other
//    behaviour is identical.
// TESTING
//  1. ALU op rd=3 alu=0x1234, mem_to_reg=0 -> next cycle write addr=3 data=0x1234 we=1.
//  2. Load mem=0x80FF_7F01: byte off=1 signed -> 0x7F; byte off=3 signed ->
//     0xFFFF_FF80; half off=2 unsigned -> 0x80FF; word -> 0x80FF_7F01.
//  3. LLU valid 6 consecutive cycles while MEM sends 6 writeable results:
//     ready drops after 4 accepts, then results drain in order once LLU stops.
//  4. Same-cycle LLU (rd=5) and MEM (rd=7): rd5 written first, rd7 one cycle later,
//    conflict_cnt=1 when WB_STALL_CNT_EN is defined.
//  5. rd=0 or reg_write=0 from either source -> no write; count unchanged; ready stays 1.
//  6. Assert rst_i with 3 entries queued -> outputs 0 and count 0 asynchronously,
//    ready=1, no stale write after release.

Source files
------------

// File: rtl/wb_stage_buf.sv
// Writeback stage: aligns and extends loads, queues pipeline results in an in-order
// FIFO and arbitrates the register-file write port against the LLU. Optional: WB_STALL_CNT_EN.
module wb_stage_buf #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          MEMWB_valid_i,
   output logic                          MEMWB_ready_o,
   input  logic [DATA_W-1:0]             MEMWB_mem_i,
   input  logic [DATA_W-1:0]             MEMWB_alu_i,
   input  logic [ADDR_W-1:0]             MEMWB_rd_i,
   input  logic                          MEMWB_ctrl_reg_write_i,
   input  logic                          MEMWB_ctrl_mem_to_reg_i,
   input  logic [1:0]                    MEMWB_ld_size_i,
   input  logic                          MEMWB_ld_unsigned_i,
   input  logic [1:0]                    MEMWB_ld_offset_i,
   input  logic                          LLU_valid_i,
   input  logic [ADDR_W-1:0]             LLU_rd_i,
   input  logic [DATA_W-1:0]             LLU_data_i,
   output logic [ADDR_W-1:0]             WB_reg_write_address_o,
   output logic [DATA_W-1:0]             WB_reg_write_data_o,
   output logic                          WB_ctrl_reg_write_o,
`ifdef WB_STALL_CNT_EN
   output logic [31:0]                   WB_stall_cnt_o,
   output logic [31:0]                   WB_conflict_cnt_o,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   WB_fifo_count_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t              fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0]   wb_data_q, wb_data_d;
   logic                wb_we_q, wb_we_d;

   logic [7:0]          byte_lane;
   logic [15:0]         half_lane;
   logic [DATA_W-1:0]   ld_data, res_data;
   logic                accept, writeable, llu_grant, fifo_empty;
   logic                pop, bypass, push;

   // Sub-word load alignment; a misaligned half simply uses offset[1].
   always_comb begin
      byte_lane = MEMWB_mem_i[{MEMWB_ld_offset_i, 3'b000} +: 8];
      half_lane = MEMWB_mem_i[{MEMWB_ld_offset_i[1], 4'b0000} +: 16];
      unique case (MEMWB_ld_size_i)
         2'b00:   ld_data = MEMWB_ld_unsigned_i ? {{(DATA_W-8){1'b0}}, byte_lane}
                                                : {{(DATA_W-8){byte_lane[7]}}, byte_lane};
         2'b01:   ld_data = MEMWB_ld_unsigned_i ? {{(DATA_W-16){1'b0}}, half_lane}
                                                : {{(DATA_W-16){half_lane[15]}}, half_lane};
         default: ld_data = MEMWB_mem_i;
      endcase
      res_data = MEMWB_ctrl_mem_to_reg_i ? ld_data : MEMWB_alu_i;
   end

   assign MEMWB_ready_o = (count_q < FULL);
   assign accept        = MEMWB_valid_i & MEMWB_ready_o;
   assign writeable     = MEMWB_ctrl_reg_write_i & (MEMWB_rd_i != '0);
   assign llu_grant     = LLU_valid_i & (LLU_rd_i != '0);
   assign fifo_empty    = (count_q == '0);
   assign pop           = ~llu_grant & ~fifo_empty;
   assign bypass        = ~llu_grant & fifo_empty & accept & writeable;
   assign push          = accept & writeable & ~bypass;

   always_comb begin
      count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      wb_we_d   = 1'b0;
      if (llu_grant) begin
         wb_addr_d = LLU_rd_i;
         wb_data_d = LLU_data_i;
         wb_we_d   = 1'b1;
      end else if (pop) begin
         wb_addr_d = fifo_q[rd_ptr_q].rd;
         wb_data_d = fifo_q[rd_ptr_q].data;
         wb_we_d   = 1'b1;
      end else if (bypass) begin
         wb_addr_d = MEMWB_rd_i;
         wb_data_d = res_data;
         wb_we_d   = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         wb_we_q   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q   <= count_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         wb_we_q   <= wb_we_d;
      end
   end

   // NOTE: storage is not reset; the count and pointers alone decide which entries are live.
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= '{rd: MEMWB_rd_i, data: res_data};
   end

   assign WB_reg_write_address_o = wb_addr_q;
   assign WB_reg_write_data_o    = wb_data_q;
   assign WB_ctrl_reg_write_o    = wb_we_q;
   assign WB_fifo_count_o        = count_q;

`ifdef WB_STALL_CNT_EN
   logic [31:0] stall_cnt_q, conflict_cnt_q;
   logic        conflict;

   // A conflict is a writeable accept that would have bypassed but lost the port to the LLU.
   assign conflict = llu_grant & fifo_empty & accept & writeable;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q    <= '0;
         conflict_cnt_q <= '0;
      end else begin
         if (MEMWB_valid_i & ~MEMWB_ready_o & (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (conflict & (conflict_cnt_q != 32'hFFFF_FFFF))
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
   end

   assign WB_stall_cnt_o    = stall_cnt_q;
   assign WB_conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
// Scoreboard bench for wb_stage_buf: expected writes are queued as stimulus is driven
// and compared as the register-file port produces them.
module tb_wb_stage_buf;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        mem_valid = 1'b0;
   logic        ready;
   logic [31:0] mem_word = '0, alu = '0;
   logic [4:0]  mem_rd = '0;
   logic        reg_write = 1'b0, mem_to_reg = 1'b0;
   logic [1:0]  ld_size = '0, ld_off = '0;
   logic        ld_uns = 1'b0;
   logic        llu_valid = 1'b0;
   logic [4:0]  llu_rd = '0;
   logic [31:0] llu_data = '0;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_we;
   logic [2:0]  fifo_count;
`ifdef WB_STALL_CNT_EN
   logic [31:0] stall_cnt, conflict_cnt;
`endif

   always #5 clk_i = ~clk_i;

   wb_stage_buf dut (
      .clk_i                   (clk_i),
      .rst_i                   (rst_i),
      .MEMWB_valid_i           (mem_valid),
      .MEMWB_ready_o           (ready),
      .MEMWB_mem_i             (mem_word),
      .MEMWB_alu_i             (alu),
      .MEMWB_rd_i              (mem_rd),
      .MEMWB_ctrl_reg_write_i  (reg_write),
      .MEMWB_ctrl_mem_to_reg_i (mem_to_reg),
      .MEMWB_ld_size_i         (ld_size),
      .MEMWB_ld_unsigned_i     (ld_uns),
      .MEMWB_ld_offset_i       (ld_off),
      .LLU_valid_i             (llu_valid),
      .LLU_rd_i                (llu_rd),
      .LLU_data_i              (llu_data),
      .WB_reg_write_address_o  (wb_addr),
      .WB_reg_write_data_o     (wb_data),
      .WB_ctrl_reg_write_o     (wb_we),
`ifdef WB_STALL_CNT_EN
      .WB_stall_cnt_o          (stall_cnt),
      .WB_conflict_cnt_o       (conflict_cnt),
`endif
      .WB_fifo_count_o         (fifo_count)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t pipe_q[$];
   int   count_m = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   last_acc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_load(input logic [31:0] m, input logic [1:0] sz,
                                            input logic uns, input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0: b = m[7:0];
         2'd1: b = m[15:8];
         2'd2: b = m[23:16];
         default: b = m[31:24];
      endcase
      h = off[1] ? m[31:16] : m[15:0];
      if (sz == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
      if (sz == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
      return m;
   endfunction

   task automatic set_mem(input logic v, input logic [4:0] rd, input logic rw, input logic m2r,
                          input logic [31:0] a, input logic [31:0] m,
                          input logic [1:0] sz, input logic uns, input logic [1:0] off);
      mem_valid = v; mem_rd = rd; reg_write = rw; mem_to_reg = m2r;
      alu = a; mem_word = m; ld_size = sz; ld_uns = uns; ld_off = off;
   endtask

   task automatic set_llu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      llu_valid = v; llu_rd = rd; llu_data = d;
   endtask

   task automatic idle();
      set_mem(1'b0, 5'd0, 1'b0, 1'b0, '0, '0, 2'b10, 1'b0, 2'b00);
      set_llu(1'b0, 5'd0, '0);
   endtask

   // One clock: predict from the current inputs, advance one edge, compare the write port.
   task automatic tick();
      bit   ready_m, acc, wr, llu, pop_m, byp, exp_we;
      exp_t e;
      ready_m = (count_m < 4);
      check("ready", ready, ready_m);
      check("count", fifo_count, count_m);
      acc = mem_valid && ready_m;
      wr  = reg_write && (mem_rd != 5'd0);
      llu = llu_valid && (llu_rd != 5'd0);
      pop_m = !llu && (count_m > 0);
      byp   = !llu && (count_m == 0) && acc && wr;
      if (acc && wr)
         pipe_q.push_back('{mem_rd, mem_to_reg ? exp_load(mem_word, ld_size, ld_uns, ld_off) : alu});
      exp_we = llu || pop_m || byp;
      e = '{5'd0, 32'd0};
      if (llu) e = '{llu_rd, llu_data};
      else if (exp_we) e = pipe_q.pop_front();
      if (acc && wr && !byp) count_m++;
      if (pop_m) count_m--;
      last_acc = acc;
      @(posedge clk_i);
      #1;
      check("we", wb_we, exp_we);
      if (exp_we) begin
         check("addr", wb_addr, e.rd);
         check("data", wb_data, e.data);
      end
   endtask

   initial begin
      int sent;
      int cyc;
      idle();
      #12;
      check("rst_we", wb_we, 1'b0);
      check("rst_addr", wb_addr, 5'd0);
      check("rst_data", wb_data, 32'd0);
      check("rst_ready", ready, 1'b1);
      check("rst_count", fifo_count, 3'd0);
      @(negedge clk_i) rst_i = 1'b0;
      @(posedge clk_i); #1;

      // ALU op, one-cycle latency
      set_mem(1'b1, 5'd3, 1'b1, 1'b0, 32'h1234, '0, 2'b10, 1'b0, 2'b00);
      tick();
      check("t1_addr", wb_addr, 5'd3);
      check("t1_data", wb_data, 32'h1234);
      check("t1_we", wb_we, 1'b1);

      // Sub-word loads
      set_mem(1'b1, 5'd4, 1'b1, 1'b1, '0, 32'h80FF_7F01, 2'b00, 1'b0, 2'd1);
      tick(); check("ld_b1s", wb_data, 32'h0000_007F);
      set_mem(1'b1, 5'd4, 1'b1, 1'b1, '0, 32'h80FF_7F01, 2'b00, 1'b0, 2'd3);
      tick(); check("ld_b3s", wb_data, 32'hFFFF_FF80);
      set_mem(1'b1, 5'd4, 1'b1, 1'b1, '0, 32'h80FF_7F01, 2'b01, 1'b1, 2'd2);
      tick(); check("ld_h2u", wb_data, 32'h0000_80FF);
      set_mem(1'b1, 5'd4, 1'b1, 1'b1, '0, 32'h80FF_7F01, 2'b10, 1'b0, 2'd3);
      tick(); check("ld_w", wb_data, 32'h80FF_7F01);

      // Same-cycle LLU and MEM
      set_mem(1'b1, 5'd7, 1'b1, 1'b0, 32'h7777, '0, 2'b10, 1'b0, 2'b00);
      set_llu(1'b1, 5'd5, 32'h5555);
      tick();
      check("t4_first", wb_addr, 5'd5);
      idle();
      tick();
      check("t4_second", wb_addr, 5'd7);
      check("t4_data", wb_data, 32'h7777);
`ifdef WB_STALL_CNT_EN
      check("t4_conflict", conflict_cnt, 32'd1);
`endif

      // Non-writeable results from both sources
      set_mem(1'b1, 5'd0, 1'b1, 1'b0, 32'hDEAD, '0, 2'b10, 1'b0, 2'b00);
      tick();
      set_mem(1'b1, 5'd9, 1'b0, 1'b0, 32'hBEEF, '0, 2'b10, 1'b0, 2'b00);
      tick();
      set_mem(1'b0, 5'd0, 1'b0, 1'b0, '0, '0, 2'b10, 1'b0, 2'b00);
      set_llu(1'b1, 5'd0, 32'hCAFE);
      tick();
      check("t5_we", wb_we, 1'b0);
      check("t5_count", fifo_count, 3'd0);
      check("t5_ready", ready, 1'b1);

      // LLU busy for 6 cycles while MEM streams 6 writeable results
      sent = 0;
      cyc = 0;
      while ((sent < 6 || pipe_q.size() != 0) && cyc < 40) begin
         set_llu(cyc < 6, 5'd20 + 5'(cyc), 32'hA000 + cyc);
         if (sent < 6) set_mem(1'b1, 5'd8 + 5'(sent), 1'b1, 1'b0, 32'h100 + sent, '0, 2'b10, 1'b0, 2'b00);
         else          set_mem(1'b0, 5'd0, 1'b0, 1'b0, '0, '0, 2'b10, 1'b0, 2'b00);
         tick();
         if (last_acc) sent++;
         cyc++;
         if (cyc == 4) begin
            check("t3_full_ready", ready, 1'b0);
            check("t3_full_count", fifo_count, 3'd4);
         end
      end
      check("t3_drained", cyc < 40, 1'b1);

      // Reset with 3 entries queued
      for (int i = 0; i < 3; i++) begin
         set_llu(1'b1, 5'd1, 32'h11 + i);
         set_mem(1'b1, 5'd12 + 5'(i), 1'b1, 1'b0, 32'h200 + i, '0, 2'b10, 1'b0, 2'b00);
         tick();
      end
      check("t6_pre_count", fifo_count, 3'd3);
      idle();
      #2 rst_i = 1'b1;
      #1;
      check("t6_we", wb_we, 1'b0);
      check("t6_addr", wb_addr, 5'd0);
      check("t6_data", wb_data, 32'd0);
      check("t6_count", fifo_count, 3'd0);
      check("t6_ready", ready, 1'b1);
      pipe_q.delete();
      count_m = 0;
      @(negedge clk_i) rst_i = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      // Random traffic
      for (int i = 0; i < 200; i++) begin
         set_llu($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom);
         set_mem($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom_range(0, 4) != 0,
                 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
         tick();
      end
      idle();
      cyc = 0;
      while (pipe_q.size() != 0 && cyc < 20) begin
         tick();
         cyc++;
      end
      check("final_empty", pipe_q.size(), 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
